// File: rtl/slave_spi.sv
// SPI mode-0 slave, 8-bit MSB-first frames, fully in the system clock domain.
// Latency: Done_o rises 4 Clock cycles after the 8th SCK rise at the pin.
// Backpressure: none; host must consume DataReceived_o on each Done_o pulse.
module slave_spi (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CS_i,
    input  logic       SCK_i,
    input  logic       MOSI_i,
    output logic       MISO_o,
    input  logic [7:0] DataToSend_i,
    output logic [7:0] DataReceived_o,
    output logic       Done_o
);

    // Synchronizer chains; the third stage of CS/SCK is the edge-detect reference
    logic       cs_s1_q, cs_s2_q, cs_s3_q;
    logic       cs_s1_d, cs_s2_d, cs_s3_d;
    logic       sck_s1_q, sck_s2_q, sck_s3_q;
    logic       sck_s1_d, sck_s2_d, sck_s3_d;
    logic       mosi_s1_q, mosi_s2_q;
    logic       mosi_s1_d, mosi_s2_d;

    // Frame state
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       wrap_q, wrap_d;
    logic       done_q, done_d;
    logic [7:0] data_rx_q, data_rx_d;

    logic       sck_rise;
    logic       sck_fall;
    logic       cs_fall;
    logic       selected;
    logic       miso_en;

    assign sck_rise = sck_s2_q & ~sck_s3_q;
    assign sck_fall = ~sck_s2_q & sck_s3_q;
    assign cs_fall  = ~cs_s2_q & cs_s3_q;
    assign selected = ~cs_s2_q;

    // Drive MISO only once the CS-fall load has landed in tx_q, release as soon as CS rises
    assign miso_en = ~cs_s2_q & ~cs_s3_q;
    assign MISO_o  = miso_en ? tx_q[7] : 1'bz;

    assign DataReceived_o = data_rx_q;
    assign Done_o         = done_q;

    // Next-state: synchronizers, RX/TX shifting, bit counter and byte-complete strobe
    always_comb begin
        cs_s1_d   = CS_i;
        cs_s2_d   = cs_s1_q;
        cs_s3_d   = cs_s2_q;
        sck_s1_d  = SCK_i;
        sck_s2_d  = sck_s1_q;
        sck_s3_d  = sck_s2_q;
        mosi_s1_d = MOSI_i;
        mosi_s2_d = mosi_s1_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        wrap_d    = 1'b0;
        // The byte is already complete in rx_q one cycle after the counter wraps
        done_d    = wrap_q;
        data_rx_d = wrap_q ? rx_q : data_rx_q;

        if (!selected) begin
            cnt_d = 3'd0;
        end else begin
            if (sck_rise) begin
                rx_d  = {rx_q[6:0], mosi_s2_q};
                cnt_d = 3'(cnt_q + 3'd1);
                if (cnt_q == 3'd7) begin
                    wrap_d = 1'b1;
                end
            end
            // CS-fall load wins over any coincident SCK fall
            if (cs_fall) begin
                tx_d = DataToSend_i;
            end else if (sck_fall) begin
                if (cnt_q == 3'd0) begin
                    tx_d = DataToSend_i;
                end else begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
        end
    end

    // State registers; synchronizers preset to idle bus levels (CS high, SCK low)
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_s3_q   <= 1'b1;
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_s3_q  <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            cnt_q     <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            data_rx_q <= 8'h00;
        end else begin
            cs_s1_q   <= cs_s1_d;
            cs_s2_q   <= cs_s2_d;
            cs_s3_q   <= cs_s3_d;
            sck_s1_q  <= sck_s1_d;
            sck_s2_q  <= sck_s2_d;
            sck_s3_q  <= sck_s3_d;
            mosi_s1_q <= mosi_s1_d;
            mosi_s2_q <= mosi_s2_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            data_rx_q <= data_rx_d;
        end
    end

endmodule

// File: tb/tb_slave_spi.sv
`timescale 1ns/1ps
// Bench for slave_spi: SPI master model, received-byte scoreboard, MISO bit checks.
// The MISO net is pulled high so a released (high-Z) output reads as 1.
module tb_slave_spi;

    localparam int CLK_HALF = 500;   // 1 MHz system clock
    localparam int SCK_HALF = 7894;  // SPI half period

    logic       clk;
    logic       rst;
    logic       cs;
    logic       sck;
    logic       mosi;
    tri1        miso;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    slave_spi dut (
        .Clock          (clk),
        .Reset          (rst),
        .CS_i           (cs),
        .SCK_i          (sck),
        .MOSI_i         (mosi),
        .MISO_o         (miso),
        .DataToSend_i   (tx_byte),
        .DataReceived_o (rx_byte),
        .Done_o         (done)
    );

    initial clk = 1'b0;
    always #CLK_HALF clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Each Done_o pulse must match the oldest byte the master fully sent while selected
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(rx_byte), 32'hFFFF_FFFF);
            end else begin
                chk("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    // Clock out n bits of b MSB-first; optionally check MISO just before each rise
    task automatic send_bits(input logic [7:0] b, input int n, input logic [7:0] exp_miso,
                             input bit check_miso, input bit push);
        if (push) exp_q.push_back(b);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            #SCK_HALF;
            if (check_miso) chk($sformatf("miso_bit%0d", i), 32'(miso), 32'(exp_miso[i]));
            sck = 1'b1;
            #SCK_HALF;
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        #SCK_HALF;
    endtask

    task automatic cs_high();
        #SCK_HALF;
        cs = 1'b1;
        #SCK_HALF;
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0; tx_byte = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        // 1: reset state
        chk("reset_rx", 32'(rx_byte), 32'h00);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_miso_z", 32'(miso), 32'h1);

        // 2: single byte, MISO carries 0x01
        tx_byte = 8'h01;
        cs_low();
        send_bits(8'h80, 8, 8'h01, 1'b1, 1'b1);
        cs_high();
        settle();
        chk("t2_rx", 32'(rx_byte), 32'h80);

        // 3: deselected clocking is ignored, MISO stays released
        tx_byte = 8'h02;
        send_bits(8'h40, 8, 8'hFF, 1'b1, 1'b0);
        settle();
        chk("t3_hold", 32'(rx_byte), 32'h80);
        chk("t3_miso_z", 32'(miso), 32'h1);

        // 4: two back-to-back bytes in one CS window, both carry 0x04 on MISO
        tx_byte = 8'h04;
        cs_low();
        send_bits(8'h20, 8, 8'h04, 1'b1, 1'b1);
        send_bits(8'h10, 8, 8'h04, 1'b1, 1'b1);
        cs_high();
        settle();
        chk("t4_rx", 32'(rx_byte), 32'h10);

        // 5: partial byte discarded, then a full byte
        tx_byte = 8'hC3;
        cs_low();
        send_bits(8'hF0, 4, 8'hC3, 1'b1, 1'b0);
        cs_high();
        settle();
        chk("t5_partial_hold", 32'(rx_byte), 32'h10);
        cs_low();
        send_bits(8'h3C, 8, 8'hC3, 1'b1, 1'b1);
        cs_high();
        settle();
        chk("t5_rx", 32'(rx_byte), 32'h3C);

        // 6: reset after 5 bits, then a clean byte
        tx_byte = 8'h5A;
        cs_low();
        send_bits(8'hFF, 5, 8'h5A, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cs_high();
        settle();
        chk("t6_reset_rx", 32'(rx_byte), 32'h00);
        chk("t6_reset_done", 32'(done), 32'h0);
        cs_low();
        send_bits(8'hA5, 8, 8'h5A, 1'b1, 1'b1);
        cs_high();
        settle();
        chk("t6_rx", 32'(rx_byte), 32'hA5);

        // Every pushed byte must have produced exactly one Done_o pulse
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
